// File: rtl/z16_pkg.sv
// Shared Z16 definitions: instruction width, NOP encoding and instruction RAM states.
package z16_pkg;

  localparam int unsigned Z16_INSTR_W = 16;

  // 0x0000 decodes as ADD ZR ZR ZR, a harmless no-op
  localparam logic [Z16_INSTR_W-1:0] Z16_NOP = 16'h0000;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } z16_iram_state_t;

endpackage

// File: rtl/z16_instr_ram_if.sv
// Fetch and program-load bus of the Z16 instruction RAM.
interface z16_instr_ram_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 9
);

  logic              i_fetch_req;
  logic [ADDR_W-1:0] i_fetch_addr;
  logic              o_fetch_ready;
  logic              o_fetch_valid;
  logic [DATA_W-1:0] o_instr;
  logic              o_fetch_err;

  logic              i_load_start;
  logic              i_load_valid;
  logic [DATA_W-1:0] i_load_data;
  logic              i_load_last;
  logic              o_load_ready;
  logic              o_load_ovf;
  logic [CNT_W-1:0]  o_load_count;

  // CPU / boot host side
  modport master (
    output i_fetch_req, i_fetch_addr,
    output i_load_start, i_load_valid, i_load_data, i_load_last,
    input  o_fetch_ready, o_fetch_valid, o_instr, o_fetch_err,
    input  o_load_ready, o_load_ovf, o_load_count
  );

  // Instruction RAM side
  modport slave (
    input  i_fetch_req, i_fetch_addr,
    input  i_load_start, i_load_valid, i_load_data, i_load_last,
    output o_fetch_ready, o_fetch_valid, o_instr, o_fetch_err,
    output o_load_ready, o_load_ovf, o_load_count
  );

endinterface

// File: rtl/z16_ram_1r1w.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, no reset.
module z16_ram_1r1w #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port; read data holds when re is low
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/z16_instr_ram.sv
// Loadable Z16 instruction RAM: zero-fill after reset/short load, 1-cycle fetch, valid/ready loader.
module z16_instr_ram
  import z16_pkg::*;
#(
  parameter int unsigned       DATA_W   = Z16_INSTR_W,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(Z16_NOP)
) (
  input logic            i_clk,
  input logic            i_rst_n,
  z16_instr_ram_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = ADDR_W - 1;

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

  z16_iram_state_t state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             fetch_err_q, fetch_err_d;
  logic             nop_sel_q, nop_sel_d;
  logic             fetch_ready_q;
  logic             load_ready_q;

  logic [IDX_W-1:0]  idx_c;
  logic              fetch_bad_c;
  logic              ram_we_c;
  logic [PTR_W-1:0]  ram_waddr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic              ram_re_c;
  logic [PTR_W-1:0]  ram_raddr_c;
  logic [DATA_W-1:0] ram_rdata;

  // Fetch address decode: word index plus misalignment / range error
  always_comb begin
    idx_c       = bus.i_fetch_addr[ADDR_W-1:1];
    fetch_bad_c = bus.i_fetch_addr[0] || (ADDR_W'(idx_c) >= DEPTH_LIM);
  end

  // Next-state, pointer, counter and RAM port control
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    count_d       = count_q;
    ovf_d         = ovf_q;
    fetch_valid_d = 1'b0;
    fetch_err_d   = 1'b0;
    nop_sel_d     = nop_sel_q;
    ram_we_c      = 1'b0;
    ram_waddr_c   = ptr_q;
    ram_wdata_c   = NOP_WORD;
    ram_re_c      = 1'b0;
    ram_raddr_c   = idx_c[PTR_W-1:0];

    case (state_q)
      CLEAR: begin
        ram_we_c = 1'b1;
        if (ptr_q == PTR_LAST) begin
          state_d = RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end

      RUN: begin
        if (bus.i_fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_err_d   = fetch_bad_c;
          nop_sel_d     = fetch_bad_c;
          ram_re_c      = !fetch_bad_c;
        end
        if (bus.i_load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end

      LOAD: begin
        if (bus.i_load_start) begin
          ptr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (bus.i_load_valid) begin
          ram_we_c    = 1'b1;
          ram_wdata_c = bus.i_load_data;
          count_d     = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
          if (ptr_q == PTR_LAST) begin
            // Array full: either exact fit or overflow; further words are dropped
            state_d = RUN;
            ptr_d   = '0;
            if (!bus.i_load_last) begin
              ovf_d = 1'b1;
            end
          end else if (bus.i_load_last) begin
            // Short image: zero-fill the remaining tail
            state_d = CLEAR;
            ptr_d   = ptr_q + PTR_W'(1);
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end

      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= CLEAR;
      ptr_q         <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      nop_sel_q     <= 1'b1;
      fetch_ready_q <= 1'b0;
      load_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      nop_sel_q     <= nop_sel_d;
      fetch_ready_q <= (state_d == RUN);
      load_ready_q  <= (state_d == LOAD);
    end
  end

  z16_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we_c && i_rst_n),
    .waddr (ram_waddr_c),
    .wdata (ram_wdata_c),
    .re    (ram_re_c && i_rst_n),
    .raddr (ram_raddr_c),
    .rdata (ram_rdata)
  );

  // RAM read data is only trusted after a good fetch; otherwise present the NOP word
  assign bus.o_instr       = nop_sel_q ? NOP_WORD : ram_rdata;
  assign bus.o_fetch_valid = fetch_valid_q;
  assign bus.o_fetch_err   = fetch_err_q;
  assign bus.o_fetch_ready = fetch_ready_q;
  assign bus.o_load_ready  = load_ready_q;
  assign bus.o_load_ovf    = ovf_q;
  assign bus.o_load_count  = count_q;

endmodule
